// File: rtl/serial_pattern_feeder.sv
// serial_pattern_feeder
// Upstream stage of the serial sequence detector. Parallel words are accepted
// over a valid/ready handshake and held in a small FIFO. They are then shifted
// out one bit per clock on ser_out. When the FIFO holds the next word at the
// last bit of the current one, that word is reloaded into the shifter. This
// gives zero-gap streaming, so patterns that span word boundaries stay intact.
// Every output is either a flop or a decode of flops. No path runs from the
// in_* inputs to the ser_* outputs.

module serial_pattern_feeder #(
  parameter int       WIDTH     = 8,
  parameter int       DEPTH     = 4,
  parameter bit       MSB_FIRST = 1'b1,
  parameter logic     IDLE_BIT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // State and storage
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  // Handshake / control strobes
  logic               in_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_nonempty_s;
  logic               last_bit_s;
  logic [WIDTH-1:0]   head_s;
  logic               cur_bit_s;

  // Advance the shifter by one bit position toward the output end.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (MSB_FIRST) begin
      result = {value[WIDTH-2:0], 1'b0};
    end else begin
      result = {1'b0, value[WIDTH-1:1]};
    end
    return result;
  endfunction

  // in_ready depends only on the registered count. A pop in the same cycle
  // does not raise it.
  assign in_ready_s      = (count_q < FULL_CNT);
  assign fifo_nonempty_s = (count_q != {CNT_W{1'b0}});
  assign push_s          = in_valid & in_ready_s & ~flush;
  assign last_bit_s      = (bit_cnt_q == LAST_BIT);
  assign head_s          = mem_q[rd_ptr_q];

  // Select the bit at the output end of the shifter.
  always_comb begin
    cur_bit_s = 1'b0;
    if (MSB_FIRST) begin
      cur_bit_s = shift_q[WIDTH-1];
    end else begin
      cur_bit_s = shift_q[0];
    end
  end

  // Shifter FSM next state. On the last bit it reloads directly from the FIFO
  // head, so the next word follows without an idle cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop_s     = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      shift_d   = {WIDTH{1'b0}};
      bit_cnt_d = {BIT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_nonempty_s) begin
            pop_s     = 1'b1;
            shift_d   = head_s;
            bit_cnt_d = {BIT_W{1'b0}};
            state_d   = ST_SHIFT;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (last_bit_s) begin
            if (fifo_nonempty_s) begin
              pop_s     = 1'b1;
              shift_d   = head_s;
              bit_cnt_d = {BIT_W{1'b0}};
              state_d   = ST_SHIFT;
            end else begin
              shift_d   = shift_one(shift_q);
              bit_cnt_d = {BIT_W{1'b0}};
              state_d   = ST_IDLE;
            end
          end else begin
            shift_d   = shift_one(shift_q);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            state_d   = ST_SHIFT;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          shift_d   = {WIDTH{1'b0}};
          bit_cnt_d = {BIT_W{1'b0}};
        end
      endcase
    end
  end

  // FIFO pointer and occupancy next state. Flush empties the FIFO. The power
  // of 2 depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and shifter registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= {WIDTH{1'b0}};
      bit_cnt_q <= {BIT_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage array. The pointers and count define the contents, so the
  // array needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready   = in_ready_s;
    ser_valid  = (state_q == ST_SHIFT);
    busy       = (state_q == ST_SHIFT) | fifo_nonempty_s;
    fifo_count = count_q;
    if (state_q == ST_SHIFT) begin
      ser_out = cur_bit_s;
    end else begin
      ser_out = IDLE_BIT;
    end
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Directed bench for serial_pattern_feeder. Instance a uses the default
// MSB-first configuration with idle 0. Instance b is LSB-first with idle 1.
module tb_serial_pattern_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_ser, b_ser;
  logic       a_sv, b_sv;
  logic       a_busy, b_busy;
  logic [2:0] a_cnt, b_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  serial_pattern_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ser_out(a_ser), .ser_valid(a_sv), .busy(a_busy), .fifo_count(a_cnt)
  );

  serial_pattern_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .ser_out(b_ser), .ser_valid(b_sv), .busy(b_busy), .fifo_count(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] msb_stream;  // expected bits on instance a, first bit in [7]
    logic [7:0] lsb_stream;  // expected bits on instance b, first bit in [7]
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic rdy;
    logic [15:0] exp16;

    vecs[0] = '{8'hB0, 8'hB0, 8'h0D};
    vecs[1] = '{8'h0D, 8'h0D, 8'hB0};
    vecs[2] = '{8'h01, 8'h01, 8'h80};
    vecs[3] = '{8'hE2, 8'hE2, 8'h47};
    vecs[4] = '{8'hA5, 8'hA5, 8'hA5};

    rst = 1'b1; flush = 1'b0;
    a_data = 8'h00; b_data = 8'h00; a_valid = 1'b0; b_valid = 1'b0;
    #12 rst = 1'b0;
    tick();

    // Reset state
    check("rst_ready_a", 32'(a_ready), 1);
    check("rst_sv_a",    32'(a_sv),    0);
    check("rst_ser_a",   32'(a_ser),   0);
    check("rst_busy_a",  32'(a_busy),  0);
    check("rst_cnt_a",   32'(a_cnt),   0);
    check("rst_ser_b",   32'(b_ser),   1);
    check("rst_sv_b",    32'(b_sv),    0);

    // Table: a single word pushed into an idle feeder, bit order per instance
    for (int v = 0; v < 5; v++) begin
      a_data = vecs[v].data; b_data = vecs[v].data;
      a_valid = 1'b1; b_valid = 1'b1;
      tick();                     // push edge
      a_valid = 1'b0; b_valid = 1'b0;
      check("push_cnt_a", 32'(a_cnt), 1);
      check("push_sv_a",  32'(a_sv),  0);
      check("push_idle_b", 32'(b_ser), 1);
      tick();                     // pop edge; bit 0 valid now
      for (int i = 0; i < 8; i++) begin
        check("bit_sv_a",   32'(a_sv),   1);
        check("bit_busy_a", 32'(a_busy), 1);
        check("bit_ser_a",  32'(a_ser),  32'(vecs[v].msb_stream[7-i]));
        check("bit_sv_b",   32'(b_sv),   1);
        check("bit_ser_b",  32'(b_ser),  32'(vecs[v].lsb_stream[7-i]));
        tick();
      end
      check("end_sv_a",   32'(a_sv),   0);
      check("end_ser_a",  32'(a_ser),  0);
      check("end_busy_a", 32'(a_busy), 0);
      check("end_sv_b",   32'(b_sv),   0);
      check("end_ser_b",  32'(b_ser),  1);
    end

    // Back-to-back words stream with no gap across the boundary
    a_data = 8'h05; a_valid = 1'b1;
    tick();
    a_data = 8'h80;
    tick();
    a_valid = 1'b0;
    check("b2b_cnt", 32'(a_cnt), 1);
    exp16 = 16'h0580;
    for (int i = 0; i < 16; i++) begin
      check("b2b_sv",  32'(a_sv),  1);
      check("b2b_ser", 32'(a_ser), 32'(exp16[15-i]));
      tick();
    end
    check("b2b_end_sv", 32'(a_sv), 0);

    // Hold in_valid until the FIFO fills; the shifter holds one extra word
    k = 0; a_data = 8'h40; a_valid = 1'b1;
    for (int e = 0; e < 5; e++) begin
      rdy = a_ready;
      tick();
      if (rdy) begin
        k++;
        a_data = 8'h40 + 8'(k);
      end
    end
    check("full_accepted", 32'(k), 5);
    check("full_cnt",      32'(a_cnt),   4);
    check("full_ready",    32'(a_ready), 0);
    for (int e = 0; e < 4; e++) begin
      tick();
      check("full_hold_ready", 32'(a_ready), 0);
      check("full_hold_cnt",   32'(a_cnt),   4);
    end
    tick();                       // last bit of first word: pop
    check("full_pop_cnt",   32'(a_cnt),   3);
    check("full_pop_ready", 32'(a_ready), 1);
    tick();                       // sixth word accepted
    a_valid = 1'b0;
    check("full_refill_cnt",   32'(a_cnt),   4);
    check("full_refill_ready", 32'(a_ready), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("full_flush_cnt", 32'(a_cnt), 0);
    check("full_flush_sv",  32'(a_sv),  0);

    // Flush at bit 3 with two words queued; the concurrent push is dropped
    a_data = 8'hFF; a_valid = 1'b1;
    tick();
    a_data = 8'hAA;
    tick();
    a_data = 8'h55;
    tick();
    a_valid = 1'b0;
    tick();
    tick();                       // bit 3 of 8'hFF
    check("fl_pre_sv",  32'(a_sv),  1);
    check("fl_pre_ser", 32'(a_ser), 1);
    check("fl_pre_cnt", 32'(a_cnt), 2);
    flush = 1'b1; a_valid = 1'b1; a_data = 8'h33;
    tick();
    flush = 1'b0; a_valid = 1'b0;
    check("fl_sv",    32'(a_sv),    0);
    check("fl_cnt",   32'(a_cnt),   0);
    check("fl_busy",  32'(a_busy),  0);
    check("fl_ready", 32'(a_ready), 1);
    tick();
    check("fl_after_sv",  32'(a_sv),  0);
    check("fl_after_cnt", 32'(a_cnt), 0);

    // Async reset in the middle of a word
    a_data = 8'h11; a_valid = 1'b1;
    tick();
    a_data = 8'h22;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    check("ar_pre_sv",  32'(a_sv),  1);
    check("ar_pre_cnt", 32'(a_cnt), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_sv",    32'(a_sv),    0);
    check("ar_cnt",   32'(a_cnt),   0);
    check("ar_ready", 32'(a_ready), 1);
    check("ar_busy",  32'(a_busy),  0);
    check("ar_ser",   32'(a_ser),   0);
    #1 rst = 1'b0;
    tick();
    check("ar_after_sv",  32'(a_sv),  0);
    check("ar_after_cnt", 32'(a_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
